// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the operand serializer and its downstream serial adder.
//   DEFAULT_BW : default width of one serial word
//   state_t    : serializer FSM states (IDLE, LOAD, SHIFT)
//   idx_width  : width of the word index counter for a given word count
// -----------------------------------------------------------------------------
package serial_pkg;

  localparam int DEFAULT_BW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  // Index counter width; never below one bit so the counter always exists.
  function automatic int idx_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/word_shift_reg.sv
// -----------------------------------------------------------------------------
// word_shift_reg
// Holds one wide operand and presents it one BW-bit word per cycle, LSB word
// first. The presented word is registered and reads 0 on any cycle that did
// not follow a shift, so the output is clean outside the streaming window.
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   i_load   capture i_data whole (never asserted together with i_shift)
//   i_shift  move the lowest word to o_word and shift the rest right by BW
//   i_data   wide operand, BW*NWORDS bits
//   o_word   registered current word
// -----------------------------------------------------------------------------
module word_shift_reg
  import serial_pkg::*;
#(
  parameter int BW     = DEFAULT_BW,
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_shift,
  input  logic [BW*NWORDS-1:0] i_data,
  output logic [BW-1:0]        o_word
);

  logic [BW*NWORDS-1:0] r_data;
  logic [BW-1:0]        r_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: r_data is only observable through r_word, which reset clears, so
      // clearing r_data is not needed for correctness; it keeps the register
      // contents deterministic after reset at the cost of one reset fan-out.
      r_data <= '0;
      r_word <= '0;
    end else begin
      if (i_load) begin
        r_data <= i_data;
      end else if (i_shift) begin
        r_data <= r_data >> BW;
      end
      r_word <= i_shift ? r_data[BW-1:0] : '0;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/operand_serializer.sv
// -----------------------------------------------------------------------------
// operand_serializer
// Accepts a wide operand pair (A, B) and streams it LSB word first to a serial
// adder: one carry-clear pulse cycle, then NWORDS word cycles with no stalls.
// A new pair may be accepted on the final word cycle, giving one operation
// every NWORDS+1 cycles back to back.
// Optional feature macro: SERIALIZER_LAST_EN adds out_last, high on the final
// word cycle only.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   in_valid       operand pair offered
//   in_ready       pair accepted this cycle (decoded from state/index only)
//   in_a, in_b     wide operands, BW*NWORDS bits each
//   out_carry_clr  one-cycle pulse one cycle before word 0
//   out_valid      out_a/out_b hold a valid word
//   out_a, out_b   current words of A and B (0 when not streaming)
//   out_last       final-word marker (SERIALIZER_LAST_EN only)
// -----------------------------------------------------------------------------
module operand_serializer
  import serial_pkg::*;
#(
  parameter int BW     = DEFAULT_BW,
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BW*NWORDS-1:0] in_a,
  input  logic [BW*NWORDS-1:0] in_b,
  output logic                 out_carry_clr,
  output logic                 out_valid,
  output logic [BW-1:0]        out_a,
  output logic [BW-1:0]        out_b
`ifdef SERIALIZER_LAST_EN
  ,
  output logic                 out_last
`endif
);

  localparam int            IW       = idx_width(NWORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_next_idx;
  logic          r_valid;
  logic          r_carry_clr;
  logic          w_at_last;
  logic          w_xfer;
  logic          w_shift_en;

  // in_ready depends only on registered state, so no path from in_valid.
  assign w_at_last = (r_state == SHIFT) && (r_idx == LAST_IDX);
  assign in_ready  = (r_state == IDLE) || w_at_last;
  assign w_xfer    = in_valid && in_ready;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    w_next_state = r_state;
    w_next_idx   = r_idx;
    case (r_state)
      IDLE: begin
        if (w_xfer) w_next_state = LOAD;
      end
      LOAD: begin
        w_next_state = SHIFT;
        w_next_idx   = '0;
      end
      SHIFT: begin
        if (w_at_last) begin
          w_next_state = w_xfer ? LOAD : IDLE;
          w_next_idx   = '0;
        end else begin
          w_next_idx = r_idx + IW'(1);
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_idx   = '0;
      end
    endcase
  end

  // Outputs are registered against the next state, so a word shifted at an
  // edge is the word shown during the SHIFT cycle that edge enters.
  assign w_shift_en = (w_next_state == SHIFT);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_valid     <= 1'b0;
      r_carry_clr <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_idx       <= w_next_idx;
      r_valid     <= w_shift_en;
      r_carry_clr <= w_xfer;
    end
  end

  assign out_valid     = r_valid;
  assign out_carry_clr = r_carry_clr;

`ifdef SERIALIZER_LAST_EN
  logic r_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b0;
    end else begin
      r_last <= w_shift_en && (w_next_idx == LAST_IDX);
    end
  end

  assign out_last = r_last;
`endif

  word_shift_reg #(.BW(BW), .NWORDS(NWORDS)) u_shift_a (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_xfer),
    .i_shift (w_shift_en),
    .i_data  (in_a),
    .o_word  (out_a)
  );

  word_shift_reg #(.BW(BW), .NWORDS(NWORDS)) u_shift_b (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_xfer),
    .i_shift (w_shift_en),
    .i_data  (in_b),
    .o_word  (out_b)
  );

endmodule

// File: tb/tb_operand_serializer.sv
// -----------------------------------------------------------------------------
// tb_operand_serializer
// Directed bench for operand_serializer (BW=16, NWORDS=4). Inputs change 1 time
// unit after the rising edge; outputs are sampled there too, once all flops of
// that edge have settled. A small serial-adder model consumes the word stream
// for the chained add/subtract cases. Define SERIALIZER_LAST_EN to also check
// out_last.
// -----------------------------------------------------------------------------
module tb_operand_serializer;

  localparam int BW     = 16;
  localparam int NWORDS = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [BW*NWORDS-1:0] in_a;
  logic [BW*NWORDS-1:0] in_b;
  logic                 out_carry_clr;
  logic                 out_valid;
  logic [BW-1:0]        out_a;
  logic [BW-1:0]        out_b;
`ifdef SERIALIZER_LAST_EN
  logic                 out_last;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  operand_serializer #(.BW(BW), .NWORDS(NWORDS)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_carry_clr (out_carry_clr),
    .out_valid     (out_valid),
    .out_a         (out_a),
    .out_b         (out_b)
`ifdef SERIALIZER_LAST_EN
    ,
    .out_last      (out_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]       a;
    logic [63:0]       b;
    logic [3:0][15:0]  ea;   // ea[k] = expected out_a on word cycle k
    logic [3:0][15:0]  eb;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation starting from IDLE. Also feeds the serial-adder model:
  // carry seeded by neg_b on the clear pulse, B inverted when neg_b is set.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0][15:0] ea, input logic [3:0][15:0] eb,
                       input logic neg_b, output logic [63:0] sum);
    logic        carry;
    logic [16:0] t;
    carry    = 1'b0;
    sum      = '0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    check("ready_idle", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    check("load_clr", out_carry_clr, 1'b1);
    check("load_valid", out_valid, 1'b0);
    check("load_ready", in_ready, 1'b0);
    check("load_out_a", out_a, 16'h0);
    if (out_carry_clr) carry = neg_b;
    tick();
    for (int k = 0; k < NWORDS; k++) begin
      check($sformatf("w%0d_valid", k), out_valid, 1'b1);
      check($sformatf("w%0d_clr", k), out_carry_clr, 1'b0);
      check($sformatf("w%0d_a", k), out_a, ea[k]);
      check($sformatf("w%0d_b", k), out_b, eb[k]);
      check($sformatf("w%0d_ready", k), in_ready, (k == NWORDS - 1));
`ifdef SERIALIZER_LAST_EN
      check($sformatf("w%0d_last", k), out_last, (k == NWORDS - 1));
`endif
      t = {1'b0, out_a} + {1'b0, (neg_b ? ~out_b : out_b)} + {16'h0, carry};
      sum[16*k +: 16] = t[15:0];
      carry = t[16];
      tick();
    end
    check("post_valid", out_valid, 1'b0);
    check("post_out_a", out_a, 16'h0);
    check("post_out_b", out_b, 16'h0);
  endtask

  logic [63:0] pa[3];
  logic [63:0] pb[3];
  logic [63:0] sum;
  int          last_cnt;

  initial begin
    vecs[0] = '{64'h0004_0003_0002_0001, 64'h0008_0007_0006_0005,
                {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                {16'h0008, 16'h0007, 16'h0006, 16'h0005}};
    vecs[1] = '{64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF,
                {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000},
                {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF}};
    vecs[2] = '{64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF,
                {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D},
                {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF}};
    vecs[3] = '{64'h8000_0000_0000_0001, 64'h0,
                {16'h8000, 16'h0000, 16'h0000, 16'h0001},
                {16'h0000, 16'h0000, 16'h0000, 16'h0000}};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_valid", out_valid, 1'b0);
    check("rst_clr", out_carry_clr, 1'b0);
    check("rst_out_a", out_a, 16'h0);
    check("rst_out_b", out_b, 16'h0);
`ifdef SERIALIZER_LAST_EN
    check("rst_last", out_last, 1'b0);
`endif
    tick();
    check("rst_ready", in_ready, 1'b1);

    // Table-driven single operations.
    for (int i = 0; i < 4; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].ea, vecs[i].eb, 1'b0, sum);
      tick();
    end

    // Chained with the serial-adder model.
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
          {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
          {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 1'b0, sum);
    check("add_carry_chain", sum, 64'h0);
    do_op(64'h5, 64'h7,
          {16'h0000, 16'h0000, 16'h0000, 16'h0005},
          {16'h0000, 16'h0000, 16'h0000, 16'h0007}, 1'b1, sum);
    check("sub_borrow_chain", sum, 64'hFFFF_FFFF_FFFF_FFFE);

    // Three operations back to back, each offered on the previous k=3 cycle.
    pa[0] = 64'h0004_0003_0002_0001; pb[0] = 64'h0008_0007_0006_0005;
    pa[1] = 64'h1111_2222_3333_4444; pb[1] = 64'h5555_6666_7777_8888;
    pa[2] = 64'hAAAA_BBBB_CCCC_DDDD; pb[2] = 64'h0F0F_F0F0_1234_ABCD;
    last_cnt = 0;
    in_valid = 1'b1;
    in_a     = pa[0];
    in_b     = pb[0];
    check("b2b_ready0", in_ready, 1'b1);
    tick();
    for (int op = 0; op < 3; op++) begin
      in_valid = 1'b0;
      check($sformatf("b2b%0d_clr", op), out_carry_clr, 1'b1);
      check($sformatf("b2b%0d_valid_load", op), out_valid, 1'b0);
      tick();
      for (int k = 0; k < NWORDS; k++) begin
        check($sformatf("b2b%0d_w%0d_a", op, k), out_a, pa[op][16*k +: 16]);
        check($sformatf("b2b%0d_w%0d_b", op, k), out_b, pb[op][16*k +: 16]);
`ifdef SERIALIZER_LAST_EN
        if (out_last) last_cnt++;
        check($sformatf("b2b%0d_w%0d_last", op, k), out_last, (k == NWORDS - 1));
`endif
        if (k == NWORDS - 1 && op < 2) begin
          in_valid = 1'b1;
          in_a     = pa[op + 1];
          in_b     = pb[op + 1];
          check($sformatf("b2b%0d_ready_k3", op), in_ready, 1'b1);
        end
        tick();
      end
    end
    in_a = '0;
    in_b = '0;
    check("b2b_idle_valid", out_valid, 1'b0);
    check("b2b_idle_clr", out_carry_clr, 1'b0);
`ifdef SERIALIZER_LAST_EN
    check("b2b_last_count", last_cnt, 3);
`endif
    tick();

    // Reset during word k=1 aborts the stream.
    in_valid = 1'b1;
    in_a     = vecs[2].a;
    in_b     = vecs[2].b;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("abort_k1_a", out_a, 16'hCAFE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_valid", out_valid, 1'b0);
    check("abort_ready", in_ready, 1'b1);
    check("abort_out_a", out_a, 16'h0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("abort_quiet%0d_valid", c), out_valid, 1'b0);
      check($sformatf("abort_quiet%0d_a", c), out_a, 16'h0);
      tick();
    end

    // Reset wins over a simultaneous transfer.
    in_valid = 1'b1;
    in_a     = vecs[0].a;
    in_b     = vecs[0].b;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    check("rstprio_clr", out_carry_clr, 1'b0);
    check("rstprio_ready", in_ready, 1'b1);
    tick();
    check("rstprio_valid", out_valid, 1'b0);
    check("rstprio_clr2", out_carry_clr, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
